// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and defaults for the pipeline memory stage.
//   - ADDR_W_DEF / DATA_W_DEF / REG_W_DEF : default widths used by mem_stage
//   - wb_sel_e    : write-back source select coming from the execute stage
//   - mem_state_e : state of the data-memory request sequencer
//   - is_misaligned() : word-alignment test on the low address bits
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_COUT = 2'b10,
    WB_ALU2 = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_REQ       = 2'b01,
    ST_WAIT_RESP = 2'b10
  } mem_state_e;

  // Word accesses only: any set bit in [1:0] is a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_req_fsm.sv
// -----------------------------------------------------------------------------
// dmem_req_fsm
// Sequencer for one data-memory access over a req/gnt/rvalid handshake.
// Owns the access latch (address, write data, direction) and the FSM
// IDLE -> REQ -> (WAIT_RESP) -> IDLE.
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   start_i               begin an access (only honoured in IDLE)
//   start_we_i            1 = store, 0 = load
//   start_addr_i          byte address to latch
//   start_wdata_i         store data to latch
//   busy_o                sequencer is not IDLE
//   done_o                access completes at the coming clock edge
//   done_load_o           the completing access is a load
//   load_data_o           load data (valid with done_o && done_load_o)
//   dmem_req_o/we_o/addr_o/wdata_o   request side of the memory port
//   dmem_gnt_i/rvalid_i/rdata_i      response side of the memory port
// -----------------------------------------------------------------------------
module dmem_req_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              start_we_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [DATA_W-1:0] start_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              done_load_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  mem_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_o      = 1'b0;
    done_load_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // gnt/rvalid arriving here belong to nothing we own and are ignored.
        if (start_i) begin
          we_d    = start_we_i;
          addr_d  = start_addr_i;
          wdata_d = start_wdata_i;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (dmem_gnt_i) begin
          if (we_q) begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end else if (dmem_rvalid_i) begin
            // Memory answered in the grant cycle: skip WAIT_RESP.
            done_o      = 1'b1;
            done_load_o = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RESP;
          end
        end
      end

      ST_WAIT_RESP: begin
        if (dmem_rvalid_i) begin
          done_o      = 1'b1;
          done_load_o = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign load_data_o = dmem_rdata_i;

  // Request fields are held in the latch, so they stay stable until gnt.
  // Outside REQ they are driven to zero to keep the bus quiet.
  assign dmem_req_o   = (state_q == ST_REQ);
  assign dmem_we_o    = dmem_req_o & we_q;
  assign dmem_addr_o  = dmem_req_o ? addr_q : '0;
  assign dmem_wdata_o = dmem_we_o ? wdata_q : '0;

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Pipeline memory stage sitting after execute. Non-memory instructions pass
// straight into the MEM/WB register (1-cycle latency); loads and stores are
// handed to dmem_req_fsm and the upstream pipeline is stalled until the
// access finishes. The MEM/WB register doubles as the MEM forwarding source.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : a load/store with result_i[1:0] != 0 issues no request,
//               completes in one cycle as a bubble (m_valid_o=1,
//               reg_write_enable_o=0) and pulses misalign_o.
//   undefined : dmem_addr_o[1:0] is forced to 00, misalign_o is tied 0.
//
// Ports
//   clk_i, rst_n_i                  clock, synchronous active-low reset
//   e_valid_i, result_i, read_data2_i, cout_i, wb_sel_i,
//   reg_write_enable_i, mem_write_enable_i, reg_write_dst_i
//                                   EX/MEM inputs from the execute stage
//   stall_o                         hold execute and all earlier stages
//   dmem_*                          data-memory req/gnt/rvalid port
//   wb_data_o, reg_write_enable_o, reg_write_dst_o, m_valid_o
//                                   MEM/WB register outputs
//   misalign_o                      misaligned-access pulse
// -----------------------------------------------------------------------------
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              e_valid_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] read_data2_i,
  input  logic [DATA_W-1:0] cout_i,
  input  logic [1:0]        wb_sel_i,
  input  logic              reg_write_enable_i,
  input  logic              mem_write_enable_i,
  input  logic [REG_W-1:0]  reg_write_dst_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              reg_write_enable_o,
  output logic [REG_W-1:0]  reg_write_dst_o,
  output logic              m_valid_o,
  output logic              misalign_o
);

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic              mem_op;
  logic              misaligned;
  logic              accept;
  logic [ADDR_W-1:0] req_addr;
  logic              unused_result_bits;

  // A store wins when both store and load-select are set.
  assign mem_op = e_valid_i && ((wb_sel_i == WB_LOAD) || mem_write_enable_i);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(result_i[1:0]);
  assign req_addr   = result_i[ADDR_W-1:0];
`else
  assign misaligned = 1'b0;
  assign req_addr   = {result_i[ADDR_W-1:2], 2'b00};
`endif

  // Upper result bits beyond ADDR_W (and dropped low bits) are not addresses.
  assign unused_result_bits = ^result_i;

  // ---------------------------------------------------------------------------
  // Memory access sequencer
  // ---------------------------------------------------------------------------
  logic              fsm_busy;
  logic              fsm_done;
  logic              fsm_done_load;
  logic [DATA_W-1:0] fsm_load_data;

  assign accept = !fsm_busy && mem_op && !misaligned;

  dmem_req_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dmem_req_fsm (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (accept),
    .start_we_i    (mem_write_enable_i),
    .start_addr_i  (req_addr),
    .start_wdata_i (read_data2_i),
    .busy_o        (fsm_busy),
    .done_o        (fsm_done),
    .done_load_o   (fsm_done_load),
    .load_data_o   (fsm_load_data),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  // The instruction presented while busy is the one execute advanced on the
  // accept cycle; it is held until the sequencer is back in IDLE.
  assign stall_o = fsm_busy;

  // ---------------------------------------------------------------------------
  // MEM/WB register plus write-back controls of the outstanding access
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              rwe_q, rwe_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic              m_valid_q, m_valid_d;
  logic [REG_W-1:0]  pend_dst_q, pend_dst_d;
  logic              pend_rwe_q, pend_rwe_d;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wb_data_q  <= '0;
      rwe_q      <= 1'b0;
      dst_q      <= '0;
      m_valid_q  <= 1'b0;
      pend_dst_q <= '0;
      pend_rwe_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      wb_data_q  <= wb_data_d;
      rwe_q      <= rwe_d;
      dst_q      <= dst_d;
      m_valid_q  <= m_valid_d;
      pend_dst_q <= pend_dst_d;
      pend_rwe_q <= pend_rwe_d;
`ifdef DMEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_comb begin
    // Default every cycle is a bubble; the pending controls hold their value.
    wb_data_d  = '0;
    rwe_d      = 1'b0;
    dst_d      = '0;
    m_valid_d  = 1'b0;
    pend_dst_d = pend_dst_q;
    pend_rwe_d = pend_rwe_q;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif

    if (!fsm_busy) begin
      if (e_valid_i) begin
        if (mem_op) begin
          if (misaligned) begin
            // Rejected access retires immediately as a non-writing result.
            m_valid_d = 1'b1;
            dst_d     = reg_write_dst_i;
`ifdef DMEM_ALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            pend_dst_d = reg_write_dst_i;
            pend_rwe_d = reg_write_enable_i && !mem_write_enable_i;
          end
        end else begin
          m_valid_d = 1'b1;
          rwe_d     = reg_write_enable_i;
          dst_d     = reg_write_dst_i;
          wb_data_d = (wb_sel_i == WB_COUT) ? cout_i : result_i;
        end
      end
    end else if (fsm_done) begin
      // Stores retire with no register write; loads carry the memory data.
      m_valid_d = 1'b1;
      dst_d     = pend_dst_q;
      if (fsm_done_load) begin
        wb_data_d = fsm_load_data;
        rwe_d     = pend_rwe_q;
      end
    end
  end

  assign wb_data_o          = wb_data_q;
  assign reg_write_enable_o = rwe_q;
  assign reg_write_dst_o    = dst_q;
  assign m_valid_o          = m_valid_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        e_valid_i;
  logic [31:0] result_i;
  logic [31:0] read_data2_i;
  logic [31:0] cout_i;
  logic [1:0]  wb_sel_i;
  logic        reg_write_enable_i;
  logic        mem_write_enable_i;
  logic [4:0]  reg_write_dst_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] wb_data_o;
  logic        reg_write_enable_o;
  logic [4:0]  reg_write_dst_o;
  logic        m_valid_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.ADDR_W(32), .DATA_W(32), .REG_W(5)) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .e_valid_i          (e_valid_i),
    .result_i           (result_i),
    .read_data2_i       (read_data2_i),
    .cout_i             (cout_i),
    .wb_sel_i           (wb_sel_i),
    .reg_write_enable_i (reg_write_enable_i),
    .mem_write_enable_i (mem_write_enable_i),
    .reg_write_dst_i    (reg_write_dst_i),
    .stall_o            (stall_o),
    .dmem_req_o         (dmem_req_o),
    .dmem_we_o          (dmem_we_o),
    .dmem_addr_o        (dmem_addr_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_gnt_i         (dmem_gnt_i),
    .dmem_rvalid_i      (dmem_rvalid_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .wb_data_o          (wb_data_o),
    .reg_write_enable_o (reg_write_enable_o),
    .reg_write_dst_o    (reg_write_dst_o),
    .m_valid_o          (m_valid_o),
    .misalign_o         (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Outputs are sampled 1 time unit after the rising edge; inputs change then.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    e_valid_i          = 1'b0;
    result_i           = '0;
    read_data2_i       = '0;
    cout_i             = '0;
    wb_sel_i           = 2'b00;
    reg_write_enable_i = 1'b0;
    mem_write_enable_i = 1'b0;
    reg_write_dst_i    = '0;
    dmem_gnt_i         = 1'b0;
    dmem_rvalid_i      = 1'b0;
    dmem_rdata_i       = '0;
  endtask

  task automatic drive_op(input logic [1:0] sel, input logic mwe, input logic [31:0] res,
                          input logic [31:0] wd, input logic [31:0] co,
                          input logic rwe, input logic [4:0] dst);
    e_valid_i          = 1'b1;
    wb_sel_i           = sel;
    mem_write_enable_i = mwe;
    result_i           = res;
    read_data2_i       = wd;
    cout_i             = co;
    reg_write_enable_i = rwe;
    reg_write_dst_i    = dst;
  endtask

  // Table of single-cycle (non-memory / bubble) vectors.
  typedef struct {
    logic        ev;
    logic [1:0]  sel;
    logic [31:0] res;
    logic [31:0] co;
    logic        rwe;
    logic [4:0]  dst;
    logic        e_valid;
    logic        e_rwe;
    logic [31:0] e_data;
  } vec_t;
  vec_t vecs [6];

  // Scoreboard records for the randomized phase.
  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        rwe;
    logic [4:0]  dst;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;
  exp_t exp_q [$];
  req_t req_q [$];
  logic [31:0] shadow [16];  // memory contents as the instruction stream sees them
  logic [31:0] ram    [16];  // memory contents as the responder holds them

  int          stall_cnt;
  logic        done_flag;
  int          n_gen;
  int          n_consumed;
  logic        prev_stall;
  logic        load_out;
  logic [3:0]  load_idx;
  logic [3:0]  ridx;
  logic [1:0]  rsel;
  logic        rmwe;
  exp_t        e_item;
  req_t        r_item;
  localparam int N_RAND = 300;

  initial begin
    vecs[0] = '{1'b1, 2'b10, 32'hFFFF0000, 32'h00001234, 1'b1, 5'd7,  1'b1, 1'b1, 32'h00001234};
    vecs[1] = '{1'b1, 2'b00, 32'hCAFEF00D, 32'h00001111, 1'b1, 5'd1,  1'b1, 1'b1, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 2'b11, 32'h0BADC0DE, 32'h00002222, 1'b0, 5'd31, 1'b1, 1'b0, 32'h0BADC0DE};
    vecs[3] = '{1'b0, 2'b00, 32'h12345678, 32'h00003333, 1'b1, 5'd4,  1'b0, 1'b0, 32'h00000000};
    vecs[4] = '{1'b1, 2'b10, 32'h00000000, 32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 2'b00, 32'h00000000, 32'h00000005, 1'b1, 5'd2,  1'b1, 1'b1, 32'h00000000};

    // ---------------- reset state ----------------
    idle_inputs();
    rst_n_i = 1'b0;
    step();
    step();
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_we", dmem_we_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_wdata", dmem_wdata_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_rwe", reg_write_enable_o, 0);
    chk("rst_dst", reg_write_dst_o, 0);
    chk("rst_mvalid", m_valid_o, 0);
    chk("rst_misalign", misalign_o, 0);
    $display("txn reset: outputs sampled after reset");
    rst_n_i = 1'b1;
    step();

    // ---------------- reset while in REQ ----------------
    drive_op(2'b01, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 5'd5);
    step();
    idle_inputs();
    chk("t1_req_up", dmem_req_o, 1);
    rst_n_i = 1'b0;
    step();
    chk("t1_req_after_rst", dmem_req_o, 0);
    chk("t1_stall_after_rst", stall_o, 0);
    chk("t1_mvalid_after_rst", m_valid_o, 0);
    chk("t1_wb_data_after_rst", wb_data_o, 0);
    rst_n_i       = 1'b1;
    dmem_gnt_i    = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h99;
    step();
    idle_inputs();
    chk("t1_late_gnt_req", dmem_req_o, 0);
    chk("t1_late_gnt_stall", stall_o, 0);
    chk("t1_late_gnt_mvalid", m_valid_o, 0);
    chk("t1_late_gnt_rwe", reg_write_enable_o, 0);
    step();
    chk("t1_quiet_mvalid", m_valid_o, 0);
    $display("txn reset-in-REQ: late gnt/rvalid applied in IDLE");

    // ---------------- table-driven non-memory vectors ----------------
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      e_valid_i          = vecs[i].ev;
      wb_sel_i           = vecs[i].sel;
      result_i           = vecs[i].res;
      cout_i             = vecs[i].co;
      reg_write_enable_i = vecs[i].rwe;
      reg_write_dst_i    = vecs[i].dst;
      read_data2_i       = 32'h5A5A5A5A;
      chk($sformatf("vec%0d_stall_in", i), stall_o, 0);
      step();
      chk($sformatf("vec%0d_mvalid", i), m_valid_o, vecs[i].e_valid);
      chk($sformatf("vec%0d_rwe", i), reg_write_enable_o, vecs[i].e_rwe);
      chk($sformatf("vec%0d_stall", i), stall_o, 0);
      chk($sformatf("vec%0d_req", i), dmem_req_o, 0);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_data", i), wb_data_o, vecs[i].e_data);
        chk($sformatf("vec%0d_dst", i), reg_write_dst_o, 32'(vecs[i].dst));
      end
      $display("txn vec%0d: sel=%0d wb_data=%h m_valid=%0d", i, vecs[i].sel, wb_data_o, m_valid_o);
    end
    idle_inputs();
    step();

    // ---------------- load, gnt after 2 cycles, rvalid 1 later ----------------
    drive_op(2'b01, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 5'd3);
    step();
    idle_inputs();
    stall_cnt = 0;
    done_flag = 1'b0;
    for (int c = 1; c <= 20 && !done_flag; c++) begin
      if (stall_o) begin
        stall_cnt++;
        chk($sformatf("t3_mvalid_c%0d", c), m_valid_o, 0);
        chk($sformatf("t3_req_c%0d", c), dmem_req_o, (c <= 3) ? 1 : 0);
        if (dmem_req_o) begin
          chk($sformatf("t3_addr_c%0d", c), dmem_addr_o, 32'h100);
          chk($sformatf("t3_we_c%0d", c), dmem_we_o, 0);
        end
        dmem_gnt_i    = (c == 3);
        dmem_rvalid_i = (c == 4);
        dmem_rdata_i  = (c == 4) ? 32'hDEADBEEF : 32'h0BAD0BAD;
        step();
        idle_inputs();
      end else begin
        done_flag = 1'b1;
      end
    end
    chk("t3_stall_cycles", stall_cnt, 4);
    chk("t3_mvalid", m_valid_o, 1);
    chk("t3_data", wb_data_o, 32'hDEADBEEF);
    chk("t3_rwe", reg_write_enable_o, 1);
    chk("t3_dst", reg_write_dst_o, 3);
    $display("txn load 0x100: stall=%0d data=%h", stall_cnt, wb_data_o);
    step();

    // ---------------- store, immediate gnt ----------------
    drive_op(2'b00, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b1, 5'd6);
    step();
    idle_inputs();
    chk("t4_req", dmem_req_o, 1);
    chk("t4_we", dmem_we_o, 1);
    chk("t4_addr", dmem_addr_o, 32'h20);
    chk("t4_wdata", dmem_wdata_o, 32'hA5A5A5A5);
    chk("t4_stall", stall_o, 1);
    dmem_gnt_i = 1'b1;
    step();
    idle_inputs();
    chk("t4_mvalid", m_valid_o, 1);
    chk("t4_rwe", reg_write_enable_o, 0);
    chk("t4_stall_after", stall_o, 0);
    chk("t4_req_after", dmem_req_o, 0);
    $display("txn store 0x20: m_valid=%0d rwe=%0d", m_valid_o, reg_write_enable_o);
    step();

    // ---------------- load followed by ALU op ----------------
    drive_op(2'b01, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 5'd10);
    step();
    drive_op(2'b00, 1'b0, 32'h55, 32'h0, 32'h0, 1'b1, 5'd9);
    chk("t5_stall1", stall_o, 1);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("t5_stall2", stall_o, 1);
    chk("t5_mvalid2", m_valid_o, 0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h7777;
    step();
    dmem_rvalid_i = 1'b0;
    chk("t5_load_mvalid", m_valid_o, 1);
    chk("t5_load_data", wb_data_o, 32'h7777);
    chk("t5_load_dst", reg_write_dst_o, 10);
    chk("t5_stall3", stall_o, 0);
    step();
    idle_inputs();
    chk("t5_alu_mvalid", m_valid_o, 1);
    chk("t5_alu_data", wb_data_o, 32'h55);
    chk("t5_alu_dst", reg_write_dst_o, 9);
    step();
    chk("t5_tail_mvalid", m_valid_o, 0);
    $display("txn load+alu: load then alu retired in order");

    // ---------------- misaligned store ----------------
    drive_op(2'b00, 1'b1, 32'h102, 32'h1, 32'h0, 1'b1, 5'd12);
    step();
    idle_inputs();
`ifdef DMEM_ALIGN_CHECK_EN
    chk("t6_req", dmem_req_o, 0);
    chk("t6_misalign", misalign_o, 1);
    chk("t6_mvalid", m_valid_o, 1);
    chk("t6_rwe", reg_write_enable_o, 0);
    chk("t6_stall", stall_o, 0);
    step();
    chk("t6_misalign_pulse", misalign_o, 0);
    chk("t6_mvalid_after", m_valid_o, 0);
`else
    chk("t6_req", dmem_req_o, 1);
    chk("t6_addr_forced", dmem_addr_o, 32'h100);
    chk("t6_misalign", misalign_o, 0);
    dmem_gnt_i = 1'b1;
    step();
    idle_inputs();
    chk("t6_mvalid", m_valid_o, 1);
    chk("t6_rwe", reg_write_enable_o, 0);
    chk("t6_misalign_after", misalign_o, 0);
`endif
    $display("txn store 0x102: misalign=%0d", misalign_o);
    step();

    // ---------------- randomized stream vs. scoreboard ----------------
    for (int i = 0; i < 16; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    idle_inputs();
    n_gen      = 0;
    n_consumed = 0;
    prev_stall = 1'b0;
    load_out   = 1'b0;
    load_idx   = '0;
    for (int cyc = 0; cyc < 20000 && (n_consumed < N_RAND || exp_q.size() != 0); cyc++) begin
      // Execute side: advances only if the previous cycle was not stalled.
      if (!prev_stall) begin
        if (n_gen < N_RAND && $urandom_range(0, 3) != 0) begin
          rsel = 2'($urandom_range(0, 3));
          rmwe = ($urandom_range(0, 3) == 0);
          ridx = 4'($urandom_range(0, 15));
          drive_op(rsel, rmwe,
                   (rmwe || rsel == 2'b01) ? (32'h200 + 32'(ridx) * 4) : $urandom,
                   $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
          n_gen++;
        end else begin
          e_valid_i = 1'b0;
        end
      end
      // Instruction consumed this cycle: record what it must produce.
      if (!stall_o && e_valid_i) begin
        n_consumed++;
        ridx = result_i[5:2];
        if (mem_write_enable_i) begin
          e_item = '{1'b0, 32'h0, 1'b0, reg_write_dst_i};
          r_item = '{result_i, 1'b1, read_data2_i};
          shadow[ridx] = read_data2_i;
          req_q.push_back(r_item);
        end else if (wb_sel_i == 2'b01) begin
          e_item = '{1'b1, shadow[ridx], reg_write_enable_i, reg_write_dst_i};
          r_item = '{result_i, 1'b0, 32'h0};
          req_q.push_back(r_item);
        end else begin
          e_item = '{1'b1, (wb_sel_i == 2'b10) ? cout_i : result_i,
                     reg_write_enable_i, reg_write_dst_i};
        end
        exp_q.push_back(e_item);
      end
      prev_stall = stall_o;

      // Memory responder with random grant / response delays.
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = $urandom;
      if (load_out) begin
        if ($urandom_range(0, 1) == 1) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = ram[load_idx];
          load_out      = 1'b0;
        end
      end else if (dmem_req_o && $urandom_range(0, 2) == 0) begin
        dmem_gnt_i = 1'b1;
        if (req_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rnd_unexpected_req: actual addr=%h required no request", dmem_addr_o);
        end else begin
          r_item = req_q.pop_front();
          chk("rnd_req_addr", dmem_addr_o, r_item.addr);
          chk("rnd_req_we", dmem_we_o, r_item.we);
          if (r_item.we) chk("rnd_req_wdata", dmem_wdata_o, r_item.wdata);
        end
        if (dmem_we_o) begin
          ram[dmem_addr_o[5:2]] = dmem_wdata_o;
        end else if ($urandom_range(0, 1) == 1) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = ram[dmem_addr_o[5:2]];
        end else begin
          load_out = 1'b1;
          load_idx = dmem_addr_o[5:2];
        end
      end

      step();

      if (m_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rnd_unexpected_valid: actual m_valid=1 required 0 (data=%h)", wb_data_o);
        end else begin
          e_item = exp_q.pop_front();
          chk("rnd_rwe", reg_write_enable_o, e_item.rwe);
          if (e_item.chk_data) begin
            chk("rnd_data", wb_data_o, e_item.data);
            chk("rnd_dst", reg_write_dst_o, 32'(e_item.dst));
          end
          $display("txn rnd: data=%h rwe=%0d dst=%0d", wb_data_o, reg_write_enable_o, reg_write_dst_o);
        end
      end
    end
    chk("rnd_consumed", n_consumed, N_RAND);
    chk("rnd_pending", exp_q.size(), 0);
    chk("rnd_req_pending", req_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
